// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if
//   Bundles every non-clock signal of the MAC sequencing controller.
//   Job request:  start, len, split_in -> busy
//   Operand port: op_valid, op_a, op_b -> op_ready
//   Multiplier:   mul_a, mul_b, mul_split out; mul_s, mul_s1, mul_s2 back
//   Result port:  res_valid, res_acc0, res_acc1, res_split; res_ready back
//   master = feeder/multiplier/consumer side, slave = the controller.
interface mac_seq_ctrl_if #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             split_in;
  logic             busy;
  logic             op_valid;
  logic             op_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic [7:0]       mul_a;
  logic [7:0]       mul_b;
  logic             mul_split;
  logic [15:0]      mul_s;
  logic [11:0]      mul_s1;
  logic [11:0]      mul_s2;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_acc0;
  logic [ACC_W-1:0] res_acc1;
  logic             res_split;

  modport master (
    output start, len, split_in, op_valid, op_a, op_b,
           mul_s, mul_s1, mul_s2, res_ready,
    input  busy, op_ready, mul_a, mul_b, mul_split,
           res_valid, res_acc0, res_acc1, res_split
  );

  modport slave (
    input  start, len, split_in, op_valid, op_a, op_b,
           mul_s, mul_s1, mul_s2, res_ready,
    output busy, op_ready, mul_a, mul_b, mul_split,
           res_valid, res_acc0, res_acc1, res_split
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl
//   Sequences operand pairs through an external combinational 8x8 / dual 8x4
//   signed multiplier and accumulates the products into one (8x8) or two
//   (split) signed accumulators, then presents them on a result handshake.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - mac_seq_ctrl_if.slave (job, operand, multiplier, result)
module mac_seq_ctrl #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             pv_q, pv_d;
  logic [7:0]       mul_a_q, mul_a_d;
  logic [7:0]       mul_b_q, mul_b_d;
  logic             split_q, split_d;
  logic [ACC_W-1:0] acc0_q, acc0_d;
  logic [ACC_W-1:0] acc1_q, acc1_d;

  logic             op_ready;
  logic             busy;
  logic             res_valid;
  logic             start_acc;
  logic             op_hs;
  logic             last_hs;
  logic [ACC_W-1:0] prod0_ext;
  logic [ACC_W-1:0] prod1_ext;

  assign start_acc = (state_q == IDLE) && bus.start;
  assign op_hs     = bus.op_valid && op_ready;
  // cnt never exceeds len-1 while in RUN, so the increment cannot wrap
  assign last_hs   = op_hs && ((cnt_q + LEN_W'(1)) == len_q);

  // Sign-extend the product(s) the multiplier returns for the registered
  // operands; the split select comes from the same register as mul_split.
  assign prod0_ext = split_q ? ACC_W'($signed(bus.mul_s1)) : ACC_W'($signed(bus.mul_s));
  assign prod1_ext = ACC_W'($signed(bus.mul_s2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = (bus.len == '0) ? DONE : RUN;
      RUN:     if (last_hs) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    op_ready  = (state_q == RUN);
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
  end

  // Datapath next-state: a start clears the job; otherwise a handshake loads
  // the multiplier operands and the pipeline flag, and a set flag folds the
  // product of the previous cycle's operands into the accumulators.
  always_comb begin
    len_d   = len_q;
    cnt_d   = cnt_q;
    pv_d    = 1'b0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    split_d = split_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    if (start_acc) begin
      len_d   = bus.len;
      split_d = bus.split_in;
      cnt_d   = '0;
      acc0_d  = '0;
      acc1_d  = '0;
    end else begin
      if (op_hs) begin
        mul_a_d = bus.op_a;
        mul_b_d = bus.op_b;
        pv_d    = 1'b1;
        cnt_d   = cnt_q + LEN_W'(1);
      end
      if (pv_q) begin
        acc0_d = acc0_q + prod0_ext;
        if (split_q) acc1_d = acc1_q + prod1_ext;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      cnt_q   <= '0;
      pv_q    <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      split_q <= 1'b0;
      acc0_q  <= '0;
      acc1_q  <= '0;
    end else begin
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      split_q <= split_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
    end
  end

  assign bus.op_ready  = op_ready;
  assign bus.busy      = busy;
  assign bus.res_valid = res_valid;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_split = split_q;
  assign bus.res_split = split_q;
  assign bus.res_acc0  = acc0_q;
  assign bus.res_acc1  = acc1_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl
//   Drives two controllers (ACC_W=24 and ACC_W=16) with identical stimulus,
//   models the external multiplier for each, and compares results against
//   a plain-arithmetic sum of products computed from the operand lists.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic signed [7:0] pa [0:255];
  logic signed [7:0] pb [0:255];

  mac_seq_ctrl_if #(.ACC_W(24), .LEN_W(8)) if24 ();
  mac_seq_ctrl_if #(.ACC_W(16), .LEN_W(8)) if16 ();

  mac_seq_ctrl #(.ACC_W(24), .LEN_W(8)) dut24 (.clk(clk), .rst_n(rst_n), .bus(if24));
  mac_seq_ctrl #(.ACC_W(16), .LEN_W(8)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  always #5 clk = ~clk;

  // The narrow instance sees exactly the same job stimulus
  assign if16.start     = if24.start;
  assign if16.len       = if24.len;
  assign if16.split_in  = if24.split_in;
  assign if16.op_valid  = if24.op_valid;
  assign if16.op_a      = if24.op_a;
  assign if16.op_b      = if24.op_b;
  assign if16.res_ready = if24.res_ready;

  // Combinational multipliers, one per controller
  assign if24.mul_s  = 16'($signed(if24.mul_a)) * 16'($signed(if24.mul_b));
  assign if24.mul_s1 = 12'($signed(if24.mul_a)) * 12'($signed(if24.mul_b[3:0]));
  assign if24.mul_s2 = 12'($signed(if24.mul_a)) * 12'($signed(if24.mul_b[7:4]));
  assign if16.mul_s  = 16'($signed(if16.mul_a)) * 16'($signed(if16.mul_b));
  assign if16.mul_s1 = 12'($signed(if16.mul_a)) * 12'($signed(if16.mul_b[3:0]));
  assign if16.mul_s2 = 12'($signed(if16.mul_a)) * 12'($signed(if16.mul_b[7:4]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one job over pa/pb[0..n-1] and checks handshake timing and sums.
  task automatic do_job(input int n, input bit sp, input int gap, input bit rand_gap,
                        input int hold, input bit poke);
    longint e0 = 0;
    longint e1 = 0;
    logic signed [3:0] lo, hi;
    for (int i = 0; i < n; i++) begin
      if (sp) begin
        lo = pb[i][3:0];
        hi = pb[i][7:4];
        e0 += longint'(pa[i]) * longint'(lo);
        e1 += longint'(pa[i]) * longint'(hi);
      end else begin
        e0 += longint'(pa[i]) * longint'(pb[i]);
      end
    end
    if24.start = 1'b1; if24.len = 8'(n); if24.split_in = sp;
    step();
    if24.start = 1'b0; if24.len = 8'($urandom); if24.split_in = 1'($urandom);
    if (n == 0) begin
      checks++; if (if24.res_valid !== 1'b1 || if24.op_ready !== 1'b0) begin errors++;
        $display("[TB] FAIL len0_done: res_valid=%b op_ready=%b exp 1/0", if24.res_valid, if24.op_ready); end
    end else begin
      checks++; if (if24.op_ready !== 1'b1 || if24.busy !== 1'b1 || if24.mul_split !== sp) begin errors++;
        $display("[TB] FAIL start_latency: op_ready=%b busy=%b mul_split=%b exp 1/1/%b",
                 if24.op_ready, if24.busy, if24.mul_split, sp); end
      for (int i = 0; i < n; i++) begin
        int g = rand_gap ? $urandom_range(0, gap) : gap;
        for (int k = 0; k < g; k++) begin
          if24.op_valid = 1'b0; if24.op_a = 8'($urandom); if24.op_b = 8'($urandom);
          step();
        end
        if24.op_valid = 1'b1; if24.op_a = pa[i]; if24.op_b = pb[i];
        #1;
        checks++; if (if24.op_ready !== 1'b1) begin errors++;
          $display("[TB] FAIL op_ready_run: pair %0d got %b exp 1", i, if24.op_ready); end
        step();
      end
      if24.op_valid = 1'b0;
      checks++; if (if24.res_valid !== 1'b0 || if24.op_ready !== 1'b0 || if24.busy !== 1'b1) begin errors++;
        $display("[TB] FAIL drain: res_valid=%b op_ready=%b busy=%b exp 0/0/1",
                 if24.res_valid, if24.op_ready, if24.busy); end
      step();
      checks++; if (if24.res_valid !== 1'b1) begin errors++;
        $display("[TB] FAIL res_latency: res_valid=%b exp 1", if24.res_valid); end
    end
    checks++; if (if24.res_acc0 !== e0[23:0] || if24.res_acc1 !== e1[23:0] || if24.res_split !== sp) begin errors++;
      $display("[TB] FAIL sum24: acc0=%h acc1=%h split=%b exp %h %h %b",
               if24.res_acc0, if24.res_acc1, if24.res_split, e0[23:0], e1[23:0], sp); end
    checks++; if (if16.res_acc0 !== e0[15:0] || if16.res_acc1 !== e1[15:0] || if16.res_valid !== 1'b1) begin errors++;
      $display("[TB] FAIL sum16: acc0=%h acc1=%h valid=%b exp %h %h 1",
               if16.res_acc0, if16.res_acc1, if16.res_valid, e0[15:0], e1[15:0]); end
    if24.res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 0) begin
        if24.start = 1'b1; if24.len = 8'd5; if24.split_in = ~sp;
      end
      if24.op_valid = 1'($urandom); if24.op_a = 8'($urandom); if24.op_b = 8'($urandom);
      step();
      if24.start = 1'b0; if24.op_valid = 1'b0;
      checks++; if (if24.res_valid !== 1'b1 || if24.op_ready !== 1'b0 || if24.res_acc0 !== e0[23:0] ||
                    if24.res_acc1 !== e1[23:0] || if24.res_split !== sp) begin errors++;
        $display("[TB] FAIL hold: valid=%b ready=%b acc0=%h acc1=%h split=%b exp 1 0 %h %h %b", if24.res_valid,
                 if24.op_ready, if24.res_acc0, if24.res_acc1, if24.res_split, e0[23:0], e1[23:0], sp); end
    end
    if24.res_ready = 1'b1;
    step();
    if24.res_ready = 1'b0;
    checks++; if (if24.res_valid !== 1'b0 || if24.busy !== 1'b0) begin errors++;
      $display("[TB] FAIL res_accept: res_valid=%b busy=%b exp 0/0", if24.res_valid, if24.busy); end
  endtask

  // Reset with random input activity, then idle with start low
  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if24.start = 1'($urandom); if24.len = 8'($urandom); if24.split_in = 1'($urandom);
      if24.op_valid = 1'($urandom); if24.op_a = 8'($urandom); if24.op_b = 8'($urandom);
      if24.res_ready = 1'($urandom);
      step();
      checks++; if ({if24.busy, if24.op_ready, if24.mul_a, if24.mul_b, if24.mul_split, if24.res_valid,
                     if24.res_acc0, if24.res_acc1, if24.res_split} !== '0) begin errors++;
        $display("[TB] FAIL reset24: busy=%b rdy=%b ma=%h mb=%h acc0=%h acc1=%h exp all 0",
                 if24.busy, if24.op_ready, if24.mul_a, if24.mul_b, if24.res_acc0, if24.res_acc1); end
      checks++; if ({if16.busy, if16.op_ready, if16.mul_a, if16.mul_b, if16.mul_split, if16.res_valid,
                     if16.res_acc0, if16.res_acc1, if16.res_split} !== '0) begin errors++;
        $display("[TB] FAIL reset16: busy=%b rdy=%b acc0=%h exp all 0", if16.busy, if16.op_ready, if16.res_acc0); end
    end
    if24.start = 1'b0; if24.op_valid = 1'b0; if24.res_ready = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (if24.busy !== 1'b0 || if24.op_ready !== 1'b0) begin errors++;
        $display("[TB] FAIL idle_hold: busy=%b op_ready=%b exp 0/0", if24.busy, if24.op_ready); end
    end
  endtask

  task automatic test_basic_8x8();
    pa[0] = 3;    pb[0] = 4;
    pa[1] = -2;   pb[1] = 5;
    pa[2] = 127;  pb[2] = -128;
    do_job(3, 1'b0, 0, 1'b0, 1, 1'b0);
  endtask

  // Upper nibble 8 of 0x81 is -8, so the second hi product is (-8)*(-8)=+64
  task automatic test_split();
    pa[0] = 5;  pb[0] = 8'h3F;
    pa[1] = -8; pb[1] = 8'h81;
    do_job(2, 1'b1, 0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_backpressure();
    pa[0] = 10; pb[0] = 10;
    pa[1] = -1; pb[1] = 1;
    do_job(2, 1'b0, 3, 1'b0, 5, 1'b1);
  endtask

  task automatic test_len0();
    do_job(0, 1'b0, 0, 1'b0, 3, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    if24.start = 1'b1; if24.len = 8'd4; if24.split_in = 1'b0;
    step();
    if24.start = 1'b0;
    if24.op_valid = 1'b1; if24.op_a = 8'd77; if24.op_b = 8'd91;
    step();
    if24.op_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (if24.busy !== 1'b0 || if24.op_ready !== 1'b0 || if24.mul_a !== 8'd0 || if24.res_acc0 !== 24'd0) begin errors++;
      $display("[TB] FAIL async_reset: busy=%b rdy=%b mul_a=%h acc0=%h exp 0", if24.busy, if24.op_ready,
               if24.mul_a, if24.res_acc0); end
    step();
    rst_n = 1'b1;
    step();
    pa[0] = 2; pb[0] = 2;
    do_job(1, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_wrap();
    pa[0] = -128; pb[0] = -128;
    pa[1] = -128; pb[1] = -128;
    do_job(2, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // Random jobs issued back-to-back: each start follows the previous accept
  task automatic test_back_to_back();
    for (int j = 0; j < 12; j++) begin
      int n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        pa[i] = 8'($urandom); pb[i] = 8'($urandom);
      end
      do_job(n, 1'($urandom), 2, 1'b1, $urandom_range(0, 2), 1'($urandom));
    end
  endtask

  initial begin
    if24.start = 1'b0; if24.len = '0; if24.split_in = 1'b0;
    if24.op_valid = 1'b0; if24.op_a = '0; if24.op_b = '0; if24.res_ready = 1'b0;
    test_reset();
    test_basic_8x8();
    test_split();
    test_backpressure();
    test_len0();
    test_reset_mid_run();
    test_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
